// File: rtl/store_narrow_unit.sv
// Store-path narrowing unit: fit-checks a 32-bit register value against the store size
// and writes the selected bytes little-endian over a byte-wide, per-byte-acked port.
module store_narrow_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        trunc_err,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  last_q;
    logic [1:0]  k_q;
    logic        trunc_q;
    logic        misalign_q;

    logic [1:0]  req_last;
    logic        req_trunc;
    logic        req_misalign;

    // Decode the incoming request: index of the final byte, alignment and fit check.
    // A signed value fits when every bit above the narrow sign bit copies that sign bit.
    always_comb begin
        req_last     = 2'd0;
        req_trunc    = 1'b0;
        req_misalign = 1'b0;
        case (req_size)
            2'b00: begin
                req_last  = 2'd0;
                req_trunc = req_signed ? !((&req_data[31:7]) || !(|req_data[31:7]))
                                       : (|req_data[31:8]);
            end
            2'b01: begin
                req_last     = 2'd1;
                req_misalign = req_addr[0];
                req_trunc    = req_signed ? !((&req_data[31:15]) || !(|req_data[31:15]))
                                          : (|req_data[31:16]);
            end
            2'b10: begin
                req_last     = 2'd3;
                req_misalign = |req_addr[1:0];
            end
            default: begin
                req_misalign = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = req_misalign ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (mem_ack && (k_q == last_q)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            last_q     <= 2'd0;
            k_q        <= 2'd0;
            trunc_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        data_q     <= req_data;
                        last_q     <= req_last;
                        k_q        <= 2'd0;
                        trunc_q    <= req_trunc;
                        misalign_q <= req_misalign;
                    end
                end
                WRITE: begin
                    if (mem_ack && (k_q != last_q)) begin
                        k_q <= k_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write-port outputs are zero outside WRITE so the port idles cleanly after a store.
    always_comb begin
        mem_wdata = 8'd0;
        if (state == WRITE) begin
            case (k_q)
                2'd0:    mem_wdata = data_q[7:0];
                2'd1:    mem_wdata = data_q[15:8];
                2'd2:    mem_wdata = data_q[23:16];
                default: mem_wdata = data_q[31:24];
            endcase
        end
    end

    assign req_ready    = (state == IDLE);
    assign mem_we       = (state == WRITE);
    assign mem_addr     = mem_we ? (addr_q + {30'd0, k_q}) : 32'd0;
    assign done         = (state == DONE);
    assign trunc_err    = done && trunc_q;
    assign misalign_err = done && misalign_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Scoreboard bench for store_narrow_unit: requests push expected writes/completions,
// a negedge monitor drives mem_ack with configurable delays and checks the DUT.
module tb_store_narrow_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_data = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic        done;
    logic        trunc_err;
    logic        misalign_err;

    store_narrow_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .done         (done),
        .trunc_err    (trunc_err),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic trunc;
        logic mis;
        int   acceptCyc;
        int   lat;
        bit   timed;
    } dn_t;

    wr_t wrQ[$];
    dn_t dnQ[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  writesSeen = 0;
    int  ackMode = 0;
    bit  holdAck = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model and monitor: ack delay per byte depends on ackMode
    // (0 immediate, 1 three wait cycles, 2 random 0..4); stray acks are thrown in while idle.
    int ackWait = 0;
    bit fresh = 1;
    always @(negedge clk) begin
        dn_t e;
        if (mem_we && !holdAck) begin
            if (fresh) begin
                ackWait = (ackMode == 0) ? 0 : (ackMode == 1) ? 3 : int'($urandom_range(0, 4));
                fresh = 0;
            end
            if (ackWait == 0) begin
                mem_ack = 1'b1;
                fresh = 1;
            end else begin
                mem_ack = 1'b0;
                ackWait--;
            end
        end else begin
            mem_ack = holdAck ? 1'b0 : ($urandom_range(0, 3) == 0);
        end

        if (mem_we) begin
            if (wrQ.size() == 0) begin
                checkOutput("unexpected mem_we", {31'd0, mem_we}, 32'd0);
            end else begin
                checkOutput("mem_addr", mem_addr, wrQ[0].addr);
                checkOutput("mem_wdata", {24'd0, mem_wdata}, {24'd0, wrQ[0].data});
                if (mem_ack) begin
                    void'(wrQ.pop_front());
                    writesSeen++;
                end
            end
        end

        if (done) begin
            if (dnQ.size() == 0) begin
                checkOutput("unexpected done", {31'd0, done}, 32'd0);
            end else begin
                e = dnQ.pop_front();
                checkOutput("writes pending at done", wrQ.size(), 32'd0);
                checkOutput("trunc_err", {31'd0, trunc_err}, {31'd0, e.trunc});
                checkOutput("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
                if (e.timed) begin
                    checkOutput("accept-to-done latency", cyc - e.acceptCyc + 1, e.lat);
                end
            end
        end else if (trunc_err || misalign_err) begin
            checkOutput("error flags without done", {30'd0, trunc_err, misalign_err}, 32'd0);
        end
    end

    // Issue one store; expectations come from plain arithmetic on the request.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] size, input logic sgn, input int mode);
        int    guard = 0;
        int    n;
        bit    mis;
        bit    trunc;
        longint sv;
        dn_t   e;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("req_ready timeout", {31'd0, req_ready}, 32'd1);
        ackMode    = mode;
        req_valid  = 1'b1;
        req_addr   = addr;
        req_data   = data;
        req_size   = size;
        req_signed = sgn;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        n   = 1 << size;
        mis = (size == 2'd3) || ((addr % n) != 0);
        sv  = longint'($signed(data));
        if (size == 2'd0)      trunc = sgn ? (sv < -128 || sv > 127) : (data > 255);
        else if (size == 2'd1) trunc = sgn ? (sv < -32768 || sv > 32767) : (data > 65535);
        else                   trunc = 0;
        if (!mis) begin
            for (int k = 0; k < n; k++) begin
                wr_t w;
                w.addr = addr + k;
                w.data = 8'((data >> (8 * k)) & 32'hFF);
                wrQ.push_back(w);
            end
        end
        e.trunc     = trunc;
        e.mis       = mis;
        e.acceptCyc = cyc;
        e.lat       = mis ? 1 : n + 1;
        e.timed     = (mode == 0);
        dnQ.push_back(e);
    endtask

    task automatic drain();
        int guard = 0;
        while ((dnQ.size() != 0 || wrQ.size() != 0) && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (guard >= 200) checkOutput("drain timeout", dnQ.size(), 32'd0);
    endtask

    initial begin
        int base;
        int g;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;

        // Reset with a request present: it must be ignored.
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h1234_5678;
        req_data  = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'd0);
        checkOutput("reset mem_wdata", {24'd0, mem_wdata}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset errors", {30'd0, trunc_err, misalign_err}, 32'd0);
        checkOutput("reset req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b1;

        applyStimulus(32'h100, 32'hFFFF_FF80, 2'd0, 1'b1, 0);
        applyStimulus(32'h100, 32'h0000_01FF, 2'd0, 1'b0, 0);
        applyStimulus(32'h100, 32'h0000_01FF, 2'd0, 1'b1, 0);
        applyStimulus(32'h100, 32'h0000_007F, 2'd0, 1'b1, 0);
        applyStimulus(32'h202, 32'h0000_1234, 2'd1, 1'b0, 0);
        applyStimulus(32'h202, 32'hFFFF_8000, 2'd1, 1'b1, 0);
        applyStimulus(32'h400, 32'hDEAD_BEEF, 2'd2, 1'b0, 1);
        applyStimulus(32'h101, 32'hDEAD_BEEF, 2'd2, 1'b0, 0);
        applyStimulus(32'h0,   32'h0000_0055, 2'd3, 1'b0, 0);
        applyStimulus(32'hFFFF_FFFC, 32'h0102_0304, 2'd2, 1'b1, 2);
        drain();

        // Abort a word store after its second byte is acked.
        base = writesSeen;
        applyStimulus(32'h800, 32'hCAFE_F00D, 2'd2, 1'b0, 0);
        g = 0;
        while (writesSeen - base < 2 && g < 50) begin
            @(posedge clk);
            g++;
        end
        if (g >= 50) checkOutput("second ack timeout", writesSeen - base, 32'd2);
        holdAck = 1;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        wrQ.delete();
        dnQ.delete();
        checkOutput("abort mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_size  = 2'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b1;
        holdAck   = 0;
        repeat (3) @(posedge clk);
        applyStimulus(32'h900, 32'h0000_00A5, 2'd0, 1'b0, 0);
        drain();

        repeat (150) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (sz != 2'd3 && $urandom_range(0, 9) < 7) a = a & ~((32'd1 << sz) - 32'd1);
            case ($urandom_range(0, 4))
                0:       d = $urandom;
                1:       d = $urandom_range(0, 255);
                2:       d = 32'($signed(8'($urandom)));
                3:       d = 32'($signed(16'($urandom)));
                default: d = $urandom_range(0, 65535);
            endcase
            applyStimulus(a, d, sz, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end
        drain();
        checkOutput("leftover writes", wrQ.size(), 32'd0);
        checkOutput("leftover dones", dnQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-path narrowing unit for the datapath: the write-side counterpart of immediate/load extension. It accepts a 32-bit register value with a store size (byte/half/word), checks whether the value fits the narrow width, and serialises the selected bytes little-endian onto a byte-wide memory write port with a per-byte ack handshake. It sits between the execute/memory stage and the byte-addressed data memory.

## Interface
- No parameters; address and data widths are fixed at 32 bits, memory port is 8 bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- req_valid  input  1  store request present
- req_ready  output  1  unit can accept a request (IDLE only)
- req_addr  input  32  byte address of the store
- req_data  input  32  register value to store
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  input  1  1: fit check is signed; 0: unsigned
- mem_we  output  1  byte write strobe, held until acked
- mem_addr  output  32  byte address of current write
- mem_wdata  output  8  byte being written
- mem_ack  input  1  memory accepted current byte (sampled only while mem_we=1)
- done  output  1  one-cycle pulse: request finished
- trunc_err  output  1  valid with done: value did not fit the size
- misalign_err  output  1  valid with done: misaligned or illegal size, nothing written

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: req_ready=1. On req_valid: latch addr, data, size, signed; compute byte count N (1/2/4), trunc and misalign flags; go to WRITE, or to DONE if misaligned.
- Misaligned: size 01 with addr[0]=1; size 10 with addr[1:0]≠0; size 11 always.
- Fit check: byte signed: data[31:7] all equal; byte unsigned: data[31:8]=0; half signed: data[31:15] all equal; half unsigned: data[31:16]=0; word never truncates. Truncation does not block the write; low bytes are stored.
- WRITE: byte index k from 0. mem_we=1, mem_addr=addr+k, mem_wdata=data[8k+7:8k]. On mem_ack: if k=N-1 go to DONE, else k+1. Outputs stable while waiting for ack.
- DONE: done=1 one cycle with trunc_err/misalign_err; then IDLE. Error outputs are 0 whenever done=0.
- mem_addr adds modulo 2^32 (word at 0xFFFFFFFC wraps cleanly; aligned access never crosses).

## Timing
- Reset (rst_n low at a clock edge): state IDLE, k=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, trunc_err=0, misalign_err=0; req_ready=1 from the next cycle. Requests presented while rst_n low are ignored.
- Reset mid-operation: aborts; mem_we drops after that edge; partially written bytes are not rolled back; no done.
- Accept at edge T (req_valid & req_ready). First mem_we at cycle T+1.
- mem_ack may be asserted in the same cycle mem_we rises; fastest byte is 1 cycle. Zero-wait latency accept→done: N+1 cycles (byte 2, half 3, word 5); misaligned: done in cycle T+1.
- req_ready=0 in WRITE and DONE; back-to-back requests accepted no sooner than the cycle after done.
- mem_ack while mem_we=0 is ignored.

## Test plan
- Byte, signed, addr 0x100, data 0xFFFFFF80, ack immediate -> one write 0x80@0x100, done at T+2, trunc_err=0.
- Byte, unsigned, data 0x000001FF -> write 0xFF, done with trunc_err=1; same data signed -> trunc_err=1; data 0x7F signed -> 0.
- Half, addr 0x202, data 0x00001234, unsigned -> 0x34@0x202 then 0x12@0x203, trunc_err=0; data 0xFFFF8000 signed -> 0x00, 0x80, trunc_err=0.
- Word, addr 0x400, data 0xDEADBEEF, mem_ack delayed 3 cycles per byte -> EF,BE,AD,DE at 0x400..0x403, outputs held during waits, done 1 cycle after 4th ack.
- Word at 0x101, and size 11 at 0x0 -> no mem_we, done+misalign_err=1 at T+1.
- Word in progress, rst_n low after 2nd byte ack -> mem_we=0 next cycle, no done, req_ready=1 after reset release; new byte request then completes normally.
